// File: rtl/debug_pkg.sv
// Shared debug-path definitions: dump framing bytes, dump FSM states and
// debug command codes used by debug_unit and dump_unit.
package debug_pkg;

    localparam logic [7:0] DUMP_HEADER = 8'hDA;
    localparam logic [7:0] DUMP_FOOTER = 8'hDF;
    localparam logic [7:0] CMD_ADVANCE = 8'hAE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_LOAD,
        S_MEM_WAIT,
        S_DONE
    } dump_state_t;

    // Which part of the frame the byte currently in tx_data belongs to.
    typedef enum logic [2:0] {
        SEC_HDR,
        SEC_PC,
        SEC_REG,
        SEC_MEM,
        SEC_FTR
    } dump_sect_t;

endpackage

// File: rtl/dump_unit.sv
// Serialises a snapshot of PC, register file and (optionally) data memory as a
// framed little-endian byte stream to uart_tx, one byte outstanding at a time.
module dump_unit
    import debug_pkg::*;
#(
    parameter int         NUM_REGS    = 32,
    parameter int         DMEM_WORDS  = 64,
    parameter logic [7:0] HEADER_BYTE = DUMP_HEADER,
    parameter logic [7:0] FOOTER_BYTE = DUMP_FOOTER
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dump_trigger_i,
    input  logic        dump_mem_mode_i,
    output logic        dump_done_o,
    input  logic [31:0] pc_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic [31:0] dmem_addr_o,
    input  logic [31:0] dmem_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int WIDX_W = $clog2(DMEM_WORDS) + 1;

    dump_state_t       state_q, state_d;
    dump_sect_t        sect_q, sect_d;
    logic              mode_q, mode_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [RIDX_W-1:0] reg_idx_q, reg_idx_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [31:0]       word_q, word_d;
    logic              reg_last;
    logic              mem_end;

    assign reg_last    = (reg_idx_q == RIDX_W'(NUM_REGS - 1));
    assign mem_end     = (word_idx_q == WIDX_W'(DMEM_WORDS));
    assign tx_start_o  = (state_q == S_SEND);
    assign dump_done_o = (state_q == S_DONE);
    assign tx_data_o   = tx_data_q;

    always_comb begin
        state_d     = state_q;
        sect_d      = sect_q;
        mode_d      = mode_q;
        byte_cnt_d  = byte_cnt_q;
        reg_idx_d   = reg_idx_q;
        word_idx_d  = word_idx_q;
        tx_data_d   = tx_data_q;
        word_d      = word_q;
        rf_addr_o   = '0;
        dmem_addr_o = '0;

        case (state_q)
            S_IDLE: begin
                if (dump_trigger_i) begin
                    mode_d     = dump_mem_mode_i;
                    word_d     = pc_i;
                    tx_data_d  = HEADER_BYTE;
                    sect_d     = SEC_HDR;
                    byte_cnt_d = '0;
                    reg_idx_d  = '0;
                    word_idx_d = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done_i) begin
                    case (sect_q)
                        SEC_FTR: state_d = S_DONE;
                        // PC was parked in the word register at trigger time.
                        SEC_HDR: begin
                            tx_data_d  = word_q[7:0];
                            sect_d     = SEC_PC;
                            byte_cnt_d = '0;
                            state_d    = S_SEND;
                        end
                        default: begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_d = S_LOAD;
                            end else begin
                                word_d    = {8'h00, word_q[31:8]};
                                tx_data_d = word_q[15:8];
                                state_d   = S_SEND;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                case (sect_q)
                    SEC_PC: begin
                        word_d    = rf_data_i;
                        tx_data_d = rf_data_i[7:0];
                        reg_idx_d = '0;
                        sect_d    = SEC_REG;
                        state_d   = S_SEND;
                    end
                    SEC_REG: begin
                        if (!reg_last) begin
                            rf_addr_o = 5'(reg_idx_q + RIDX_W'(1));
                            word_d    = rf_data_i;
                            tx_data_d = rf_data_i[7:0];
                            reg_idx_d = reg_idx_q + RIDX_W'(1);
                            state_d   = S_SEND;
                        end else if (mode_q) begin
                            dmem_addr_o = 32'({word_idx_q, 2'b00});
                            sect_d      = SEC_MEM;
                            state_d     = S_MEM_WAIT;
                        end else begin
                            tx_data_d = FOOTER_BYTE;
                            sect_d    = SEC_FTR;
                            state_d   = S_SEND;
                        end
                    end
                    SEC_MEM: begin
                        if (!mem_end) begin
                            dmem_addr_o = 32'({word_idx_q, 2'b00});
                            state_d     = S_MEM_WAIT;
                        end else begin
                            tx_data_d = FOOTER_BYTE;
                            sect_d    = SEC_FTR;
                            state_d   = S_SEND;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM_WAIT: begin
                word_d     = dmem_data_i;
                tx_data_d  = dmem_data_i[7:0];
                word_idx_d = word_idx_q + WIDX_W'(1);
                state_d    = S_SEND;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sect_q     <= SEC_HDR;
            mode_q     <= 1'b0;
            byte_cnt_q <= '0;
            reg_idx_q  <= '0;
            word_idx_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sect_q     <= sect_d;
            mode_q     <= mode_d;
            byte_cnt_q <= byte_cnt_d;
            reg_idx_q  <= reg_idx_d;
            word_idx_q <= word_idx_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // The word shift register carries data only; it is always reloaded before use.
    always_ff @(posedge clk_i) begin
        word_q <= word_d;
    end

endmodule

// File: tb/tb_dump_unit.sv
// Bench for dump_unit: uart_tx / register-file / data-memory models around the
// DUT, a frame-level reference model, a vector table and directed corner cases.
module tb_dump_unit;
    import debug_pkg::*;

    localparam int NUM_REGS   = 32;
    localparam int DMEM_WORDS = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dump_trigger_i;
    logic        dump_mem_mode_i;
    logic        dump_done_o;
    logic [31:0] pc_i;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_done_i;

    dump_unit #(
        .NUM_REGS   (NUM_REGS),
        .DMEM_WORDS (DMEM_WORDS),
        .HEADER_BYTE(8'hDA),
        .FOOTER_BYTE(8'hDF)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dump_trigger_i (dump_trigger_i),
        .dump_mem_mode_i(dump_mem_mode_i),
        .dump_done_o    (dump_done_o),
        .pc_i           (pc_i),
        .rf_addr_o      (rf_addr_o),
        .rf_data_i      (rf_data_i),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_data_i    (dmem_data_i),
        .tx_data_o      (tx_data_o),
        .tx_start_o     (tx_start_o),
        .tx_done_i      (tx_done_i)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] rf_mem [NUM_REGS];
    logic [31:0] dmem   [DMEM_WORDS];
    assign rf_data_i = rf_mem[rf_addr_o];

    int          total = 0;
    int          bad = 0;
    int          tx_delay = 1;
    bit          spur = 1'b0;
    int          done_cnt = 0;
    int          stable_bad = 0;
    int          double_start = 0;
    logic [7:0]  bytes [$];
    logic [7:0]  exp_q [$];
    logic [31:0] addr_q [$];

    typedef struct {
        bit          mode;
        bit          rnd;
        logic [31:0] pc;
        int          delay;
        int          exp_len;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // uart_tx model: answers each tx_start_o with tx_done_i after tx_delay cycles
    // (tx_delay == 0 picks a random 1..6 per byte) and logs the byte stream.
    initial begin : uart_model
        bit         pending;
        int         cnt;
        logic [7:0] held;
        pending   = 1'b0;
        cnt       = 0;
        held      = '0;
        tx_done_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            tx_done_i = 1'b0;
            if (rst_i) begin
                pending = 1'b0;
            end else begin
                if (dump_done_o) done_cnt++;
                if (pending) begin
                    if (tx_data_o !== held) stable_bad++;
                    cnt--;
                    if (cnt <= 0) begin
                        tx_done_i = 1'b1;
                        pending   = 1'b0;
                    end
                end else begin
                    tx_done_i = spur;
                end
                if (tx_start_o) begin
                    if (pending) double_start++;
                    bytes.push_back(tx_data_o);
                    held    = tx_data_o;
                    pending = 1'b1;
                    cnt     = (tx_delay == 0) ? int'($urandom_range(6, 1)) : tx_delay;
                end
            end
        end
    end

    // Synchronous-read data memory: address seen in one cycle, data valid the next.
    initial begin : dmem_model
        logic [31:0] a;
        dmem_data_i = '0;
        forever begin
            @(negedge clk_i);
            a = dmem_addr_o;
            if (a != 32'h0) addr_q.push_back(a);
            @(posedge clk_i); #1;
            dmem_data_i = dmem[a[7:2]];
        end
    end

    task automatic set_patterns(input bit rnd);
        for (int k = 0; k < NUM_REGS; k++)
            rf_mem[k] = rnd ? $urandom : 32'h1000_0000 + k;
        for (int k = 0; k < DMEM_WORDS; k++)
            dmem[k] = rnd ? $urandom : (32'hA5A5_0000 | k);
    endtask

    task automatic clear_mon();
        bytes.delete();
        addr_q.delete();
        done_cnt     = 0;
        stable_bad   = 0;
        double_start = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
    endtask

    task automatic build_expected(input bit mode, input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(8'hDA);
        push_word(pc);
        for (int k = 0; k < NUM_REGS; k++) push_word(rf_mem[k]);
        if (mode)
            for (int k = 0; k < DMEM_WORDS; k++) push_word(dmem[k]);
        exp_q.push_back(8'hDF);
    endtask

    task automatic compare_stream(input string name);
        int nmis;
        nmis = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= bytes.size() || bytes[i] !== exp_q[i]) nmis++;
        chk({name, " length"}, bytes.size(), exp_q.size());
        chk({name, " byte mismatches"}, nmis, 0);
    endtask

    function automatic logic [7:0] b(input int i);
        return (i < bytes.size()) ? bytes[i] : 8'hxx;
    endfunction

    task automatic start_dump(input bit mode, input logic [31:0] pc, input string name);
        @(negedge clk_i);
        dump_mem_mode_i = mode;
        pc_i            = pc;
        dump_trigger_i  = 1'b1;
        @(posedge clk_i); #1;
        chk({name, " start latency"}, tx_start_o, 1);
        chk({name, " header"}, tx_data_o, 8'hDA);
        @(negedge clk_i);
        dump_trigger_i  = 1'b0;
        dump_mem_mode_i = ~mode;
        pc_i            = ~pc;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 30000) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({name, " done seen"}, (done_cnt > 0), 1);
        repeat (5) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_bytes(input int cnt, input string name);
        int n;
        n = 0;
        while (bytes.size() < cnt && n < 5000) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({name, " byte count reached"}, (bytes.size() >= cnt), 1);
    endtask

    initial begin : main
        string nm;
        int    n;
        int    amis;

        rst_i           = 1'b1;
        dump_trigger_i  = 1'b0;
        dump_mem_mode_i = 1'b0;
        pc_i            = '0;
        set_patterns(1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset tx_start", tx_start_o, 0);
        chk("reset tx_data", tx_data_o, 0);
        chk("reset dump_done", dump_done_o, 0);
        chk("reset rf_addr", rf_addr_o, 0);
        chk("reset dmem_addr", dmem_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // tx_done_i while idle must not start anything
        clear_mon();
        spur = 1'b1;
        repeat (6) @(posedge clk_i);
        spur = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("idle tx_done ignored", bytes.size(), 0);
        chk("idle no done", done_cnt, 0);

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 1,  134};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 1,  390};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 20, 134};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 20, 390};
        vecs[4] = '{1'b0, 1'b1, $urandom,      0,  134};
        vecs[5] = '{1'b1, 1'b1, $urandom,      0,  390};

        for (int v = 0; v < 6; v++) begin
            nm = $sformatf("v%0d", v);
            clear_mon();
            set_patterns(vecs[v].rnd);
            tx_delay = vecs[v].delay;
            start_dump(vecs[v].mode, vecs[v].pc, nm);
            wait_done(nm);
            build_expected(vecs[v].mode, vecs[v].pc);
            chk({nm, " frame length"}, bytes.size(), vecs[v].exp_len);
            compare_stream(nm);
            chk({nm, " done pulses"}, done_cnt, 1);
            chk({nm, " tx_data stable"}, stable_bad, 0);
            chk({nm, " one start per byte"}, double_start, 0);
            if (!vecs[v].rnd) begin
                chk({nm, " byte0"}, b(0), 8'hDA);
                chk({nm, " pc bytes"}, {b(1), b(2), b(3), b(4)}, 32'h4000_0000);
                chk({nm, " reg31 bytes"}, {b(129), b(130), b(131), b(132)}, 32'h1F00_0010);
                chk({nm, " last byte"}, b(vecs[v].exp_len - 1), 8'hDF);
                if (vecs[v].mode) begin
                    chk({nm, " byte133"}, b(133), 8'h00);
                    chk({nm, " last dmem word"}, {b(385), b(386), b(387), b(388)}, 32'h3F00_A5A5);
                    chk({nm, " dmem addr count"}, addr_q.size(), DMEM_WORDS - 1);
                    amis = 0;
                    for (int i = 0; i < addr_q.size(); i++)
                        if (addr_q[i] !== 32'((i + 1) * 4)) amis++;
                    chk({nm, " dmem addr steps"}, amis, 0);
                end
            end
        end

        // Re-trigger mid-frame with changed mode/pc, then trigger during the done pulse
        clear_mon();
        set_patterns(1'b0);
        tx_delay = 1;
        start_dump(1'b0, 32'h0000_0040, "rt");
        wait_bytes(10, "rt");
        @(negedge clk_i);
        dump_trigger_i  = 1'b1;
        dump_mem_mode_i = 1'b1;
        pc_i            = 32'hDEAD_BEEF;
        @(negedge clk_i);
        dump_trigger_i  = 1'b0;
        n = 0;
        while (!dump_done_o && n < 5000) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("rt done reached", dump_done_o, 1);
        dump_trigger_i = 1'b1;
        @(posedge clk_i); #1;
        dump_trigger_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        build_expected(1'b0, 32'h0000_0040);
        chk("rt frame length", bytes.size(), 134);
        compare_stream("rt");
        chk("rt done pulses", done_cnt, 1);
        chk("rt idle after done", tx_start_o, 0);

        // Reset in the middle of a frame, then a fresh full frame
        clear_mon();
        start_dump(1'b0, 32'h1234_5678, "rs");
        wait_bytes(50, "rs");
        rst_i = 1'b1;
        #1;
        chk("rs tx_start", tx_start_o, 0);
        chk("rs tx_data", tx_data_o, 0);
        chk("rs dump_done", dump_done_o, 0);
        chk("rs dmem_addr", dmem_addr_o, 0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("rs truncated", bytes.size(), 50);
        chk("rs no done", done_cnt, 0);
        clear_mon();
        start_dump(1'b0, 32'h0000_0100, "rs2");
        wait_done("rs2");
        build_expected(1'b0, 32'h0000_0100);
        compare_stream("rs2");
        chk("rs2 done pulses", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
